data_mem_resp: RTL and testbench
================================

// Module: data_mem_resp
// PURPOSE
//  Data-memory responder on the EX/MEM side of the pipeline. It consumes the MemRead,
//  MemWrite, Address and Write_data fields driven by the EX/MEM pipeline register.
//  It models a word-addressed data RAM with a configurable access latency.
//  It raises stall_o so the pipeline holds EX/MEM stable until the access completes,
//  and returns read data for the MEM/WB register.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; legal word index 0..DEPTH_WORDS-1
//  LATENCY      2    extra cycles per access, 0..15; 0 = single-cycle, no stall
// PORTS
//  clk_i         in   1   clock; all state changes on rising edge
//  rst_i         in   1   reset, asynchronous, active-low
//  MemRead_i     in   1   read request, held while stall_o=1
//  MemWrite_i    in   1   write request, held while stall_o=1
//  Address_i     in   32  byte address (ALU result)
//  Write_data_i  in   32  store data
//  Read_data_o   out  32  load data; valid in the completion cycle
//  stall_o       out  1   1 = pipeline must freeze PC, IF/ID, ID/EX, EX/MEM
//  err_o         out  1   1-cycle flag: misaligned or out-of-range request
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, cnt=0, rdata_q=0.
//   Outputs during reset: Read_data_o=0, stall_o=0, err_o=0.
//   RAM contents are not cleared.
//  req = MemRead_i | MemWrite_i. Both high: treated as write; err_o=1 in that cycle.
//  Illegal request: Address_i[1:0]!=0 or Address_i[31:2]>=DEPTH_WORDS.
//   err_o=1 in the cycle it is presented; the request is dropped.
//   No RAM access, no stall, Read_data_o=0.
//  LATENCY=0: combinational read, Read_data_o=mem[Address_i[31:2]].
//   Write committed on the rising edge; stall_o tied 0.
//  LATENCY>=1 FSM:
//   IDLE: legal req -> stall_o=1.
//    Edge: state=BUSY, cnt=LATENCY-1, rdata_q<=mem[idx].
//   BUSY, cnt!=0: stall_o=1; cnt decrements each edge.
//   BUSY, cnt==0 (completion cycle): stall_o=0, Read_data_o=rdata_q.
//    Edge: a write commits mem[idx]<=Write_data_i; state=IDLE.
//   Total request cycles = LATENCY+1; stall cycles = LATENCY.
//  Back-to-back: IDLE in the cycle after completion samples the new EX/MEM contents.
//   There is no dead cycle beyond the FSM.
//  Read_data_o outside the completion cycle: rdata_q held (read) or 0 (after write).
//  req deasserted while BUSY (protocol violation): abort to IDLE, no write, err_o=1.
//  Reset mid-BUSY: abort, no write, outputs at reset values.
//  Read-after-write to the same index in consecutive requests returns the new data.
// TESTING
//  1. LATENCY=2; write 0xDEADBEEF @0x10.
//     -> stall_o=1 for 2 cycles; mem[4]=0xDEADBEEF after completion edge.
//  2. Read @0x10 after test 1.
//     -> stall_o 1,1,0; Read_data_o=0xDEADBEEF in cycle 3.
//  3. Read @0x13 (misaligned).
//     -> err_o=1 for 1 cycle, stall_o=0, Read_data_o=0, RAM unchanged.
//  4. Write @0x400 with DEPTH_WORDS=256.
//     -> err_o=1, no stall, mem unchanged.
//  5. Write 0x12345678 @0x20; rst_i=0 during 1st BUSY cycle.
//     -> stall_o=0 at once; mem[8] keeps its old value.
//  6. LATENCY=0; write 0xA5A5A5A5 @0x8, then read @0x8 next cycle.
//     -> Read_data_o=0xA5A5A5A5 the same cycle, stall_o never 1.

Source files
------------

// File: rtl/data_mem_resp.sv
// Word-addressed data RAM responder for the EX/MEM stage.
// It adds a configurable access latency and holds the pipeline with stall_o until the access completes.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_data_i,
    output logic [31:0] Read_data_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    logic [31:0]      mem [DEPTH_WORDS];
    logic             req;
    logic             both;
    logic             addr_ok;
    logic             legal;
    logic [IDX_W-1:0] idx;
    logic             mem_we;

    // Legality depends only on the address, so it can be decoded once for both latency modes
    always_comb begin
        req     = MemRead_i | MemWrite_i;
        both    = MemRead_i & MemWrite_i;
        addr_ok = (Address_i[1:0] == 2'b00) &&
                  ({2'b00, Address_i[31:2]} < 32'(DEPTH_WORDS));
        legal   = req & addr_ok;
        idx     = Address_i[IDX_W+1:2];
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= Write_data_i;
        end
    end

    generate
        if (LATENCY == 0) begin : g_single_cycle
            always_comb begin
                stall_o     = 1'b0;
                err_o       = 1'b0;
                Read_data_o = 32'd0;
                mem_we      = 1'b0;
                if (rst_i) begin
                    err_o  = req & (~addr_ok | both);
                    mem_we = legal & MemWrite_i;
                    if (legal && !MemWrite_i) begin
                        Read_data_o = mem[idx];
                    end
                end
            end
        end else begin : g_multi_cycle
            state_e      state_q, state_d;
            logic [3:0]  cnt_q, cnt_d;
            logic [31:0] rdata_q, rdata_d;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                    rdata_q <= 32'd0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    rdata_q <= rdata_d;
                end
            end

            // Read data is captured at acceptance; EX/MEM holds the request stable until completion
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                rdata_d = rdata_q;
                case (state_q)
                    IDLE: begin
                        if (legal) begin
                            state_d = BUSY;
                            cnt_d   = 4'(LATENCY - 1);
                            rdata_d = MemWrite_i ? 32'd0 : mem[idx];
                        end
                    end
                    BUSY: begin
                        if (!req || cnt_q == 4'd0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end

            // Outputs are forced to their reset values while rst_i is low, even with a request held
            always_comb begin
                stall_o     = 1'b0;
                err_o       = 1'b0;
                Read_data_o = 32'd0;
                mem_we      = 1'b0;
                if (rst_i) begin
                    Read_data_o = rdata_q;
                    case (state_q)
                        IDLE: begin
                            if (req) begin
                                err_o = ~addr_ok | both;
                                if (legal) begin
                                    stall_o = 1'b1;
                                end else begin
                                    Read_data_o = 32'd0;
                                end
                            end
                        end
                        BUSY: begin
                            if (!req) begin
                                err_o = 1'b1;
                            end else if (cnt_q != 4'd0) begin
                                stall_o = 1'b1;
                            end else begin
                                mem_we = MemWrite_i;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: one instance with latency 2 and one with latency 0.
// Expected values are hand-computed.
module tb_data_mem_resp;

   logic        clk;
   logic        rstN;

   logic        rd2, wr2, stall2, err2;
   logic [31:0] addr2, wdata2, rdata2;
   logic        rd0, wr0, stall0, err0;
   logic [31:0] addr0, wdata0, rdata0;

   int checks   = 0;
   int failures = 0;

   data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (
      .clk_i       (clk),
      .rst_i       (rstN),
      .MemRead_i   (rd2),
      .MemWrite_i  (wr2),
      .Address_i   (addr2),
      .Write_data_i(wdata2),
      .Read_data_o (rdata2),
      .stall_o     (stall2),
      .err_o       (err2)
   );

   data_mem_resp #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_l0 (
      .clk_i       (clk),
      .rst_i       (rstN),
      .MemRead_i   (rd0),
      .MemWrite_i  (wr0),
      .Address_i   (addr0),
      .Write_data_i(wdata0),
      .Read_data_o (rdata0),
      .stall_o     (stall0),
      .err_o       (err0)
   );

   // Free-running clock with rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value with its expected value and counts the comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drives the request fields of either the latency-2 or the latency-0 instance
   task automatic applyStimulus(input bit toL0, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] data);
      if (toL0) begin
         rd0 = rd; wr0 = wr; addr0 = addr; wdata0 = data;
      end else begin
         rd2 = rd; wr2 = wr; addr2 = addr; wdata2 = data;
      end
   endtask

   // Starts a new cycle one time unit after the rising edge
   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   // Runs one legal latency-2 access over three cycles: two stall cycles then completion
   task automatic doAccess(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input bit expErrA, input logic [31:0] expRd);
      nextCycle();
      applyStimulus(1'b0, rd, wr, addr, data);
      @(negedge clk);
      checkOutput({tag, "_stallA"}, {31'd0, stall2}, 32'd1);
      checkOutput({tag, "_errA"}, {31'd0, err2}, {31'd0, expErrA});
      nextCycle();
      @(negedge clk);
      checkOutput({tag, "_stallB"}, {31'd0, stall2}, 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput({tag, "_stallC"}, {31'd0, stall2}, 32'd0);
      checkOutput({tag, "_rdataC"}, rdata2, expRd);
   endtask

   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      #2;
      checkOutput("rst_rdata2", rdata2, 32'd0);
      checkOutput("rst_stall2", {31'd0, stall2}, 32'd0);
      checkOutput("rst_err2", {31'd0, err2}, 32'd0);
      checkOutput("rst_rdata0", rdata0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;

      doAccess("init0", 1'b0, 1'b1, 32'h0, 32'h1111_1111, 1'b0, 32'd0);
      doAccess("init20", 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'd0);

      // Write then back-to-back read of the same word
      doAccess("t1_wr", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
      doAccess("t2_rd", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("t2_hold", rdata2, 32'hDEAD_BEEF);

      nextCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h13, 32'd0);
      @(negedge clk);
      checkOutput("t3_err", {31'd0, err2}, 32'd1);
      checkOutput("t3_stall", {31'd0, stall2}, 32'd0);
      checkOutput("t3_rdata", rdata2, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("t3_err_clr", {31'd0, err2}, 32'd0);

      // Word index 256 must not alias onto word 0
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h400, 32'hBAD0_BAD0);
      @(negedge clk);
      checkOutput("t4_err", {31'd0, err2}, 32'd1);
      checkOutput("t4_stall", {31'd0, stall2}, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      doAccess("t4_rd0", 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 32'h1111_1111);

      doAccess("both_wr", 1'b1, 1'b1, 32'h24, 32'h0000_0077, 1'b1, 32'd0);
      doAccess("both_rd", 1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 32'h0000_0077);

      // Request dropped while busy aborts without writing
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h0000_0055);
      @(negedge clk);
      checkOutput("abort_stallA", {31'd0, stall2}, 32'd1);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("abort_err", {31'd0, err2}, 32'd1);
      checkOutput("abort_stall", {31'd0, stall2}, 32'd0);
      doAccess("abort_rd", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hCAFE_F00D);

      // Reset asserted in the first busy cycle with the request still held
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
      @(negedge clk);
      checkOutput("t5_stallA", {31'd0, stall2}, 32'd1);
      nextCycle();
      rstN = 1'b0;
      #1;
      checkOutput("t5_stall", {31'd0, stall2}, 32'd0);
      checkOutput("t5_err", {31'd0, err2}, 32'd0);
      checkOutput("t5_rdata", rdata2, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      nextCycle();
      rstN = 1'b1;
      doAccess("t5_rd", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'hCAFE_F00D);
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

      // Zero-latency instance
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 32'hA5A5_A5A5);
      @(negedge clk);
      checkOutput("t6_wr_stall", {31'd0, stall0}, 32'd0);
      checkOutput("t6_wr_err", {31'd0, err0}, 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h8, 32'd0);
      @(negedge clk);
      checkOutput("t6_rd_data", rdata0, 32'hA5A5_A5A5);
      checkOutput("t6_rd_stall", {31'd0, stall0}, 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'hA, 32'd0);
      @(negedge clk);
      checkOutput("t6_mis_err", {31'd0, err0}, 32'd1);
      checkOutput("t6_mis_data", rdata0, 32'd0);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hC, 32'h0000_00C3);
      @(negedge clk);
      checkOutput("t6_both_err", {31'd0, err0}, 32'd1);
      nextCycle();
      applyStimulus(1'b1, 1'b1, 1'b0, 32'hC, 32'd0);
      @(negedge clk);
      checkOutput("t6_both_rd", rdata0, 32'h0000_00C3);
      nextCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
